// File: rtl/scan_display_driver_pkg.sv
// Shared definitions for the microwave timer display driver.
//   - 7-segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   - bcd_t digit type and the mod-10 increment used by the mm:ss normaliser
package scan_display_driver_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // (d + 1) mod 10 evaluated on the raw nibble, so a non-BCD value in the
  // minutes digit still lands on a defined result.
  function automatic bcd_t bcd_inc_mod10(input bcd_t d);
    logic [4:0] s;
    s = {1'b0, d} + 5'd1;
    return bcd_t'(s % 5'd10);
  endfunction

endpackage

// File: rtl/scan_display_driver_if.sv
// Controller-side bus of the scan display driver.
//   load, digits_in, blink_en, blank_lead : controller -> driver
//   seg_out, an_out                       : driver -> pins
// master = timer controller / board side, slave = the driver itself.
interface scan_display_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic                    blink_en;
  logic                    blank_lead;
  logic [6:0]              seg_out;
  logic [N_DIGITS-1:0]     an_out;

  modport master (
    output load, digits_in, blink_en, blank_lead,
    input  seg_out, an_out
  );

  modport slave (
    input  load, digits_in, blink_en, blank_lead,
    output seg_out, an_out
  );
endinterface

// File: rtl/scan_display_driver_decode.sv
// BCD digit to 7-segment pattern, combinational, active-high.
//   bcd : 4-bit digit value
//   seg : {g,f,e,d,c,b,a}; 0..9 standard glyphs, 10..15 a dash
module scan_display_driver_decode
  import scan_display_driver_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/scan_display_driver.sv
// Time-multiplexed N-digit 7-segment driver for the microwave timer.
//   clk, reset : clock and synchronous active-high reset
//   bus.load / bus.digits_in : capture a BCD word (normalised to mm:ss)
//   bus.blink_en   : blink whole display (segments off, anodes keep scanning)
//   bus.blank_lead : leading-zero blanking (digit 0 never blanked)
//   bus.seg_out / bus.an_out : registered segment bus and one-hot anode
module scan_display_driver
  import scan_display_driver_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 64,
  parameter int NORM_MMSS  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  scan_display_driver_if.slave  bus
);
  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // Digit positions of seconds-tens and minutes-units, clamped so small
  // displays still elaborate; the normaliser is disabled for them anyway.
  localparam int D1 = (N_DIGITS >= 2) ? 1 : 0;
  localparam int D2 = (N_DIGITS >= 3) ? 2 : 0;
  localparam logic [6:0]          SEG_POL = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

  bcd_t                norm       [N_DIGITS];
  bcd_t                shadow_p0  [N_DIGITS];
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       blink_cnt;
  logic                phase_on;
  logic                slot_end;
  logic                round_end;
  logic [N_DIGITS-1:0] lead_blank;
  logic [N_DIGITS-1:0] an_hot;
  logic [6:0]          seg_pat;
  logic                blank_cur;
  logic [6:0]          seg_p1;
  logic [N_DIGITS-1:0] an_p1;

  // mm:ss normalisation: a seconds-tens digit of 6..9 carries one minute.
  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) norm[k] = bus.digits_in[4*k +: 4];
    if (NORM_MMSS != 0 && N_DIGITS >= 3 && norm[D1] >= 4'd6 && norm[D1] <= 4'd9) begin
      norm[D1] = norm[D1] - 4'd6;
      norm[D2] = bcd_inc_mod10(norm[D2]);
    end
  end

  // ---- stage p0: shadow digits, scan and blink state ----
  assign slot_end  = (presc == PW'(SCAN_DIV - 1));
  assign round_end = slot_end && (idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_DIGITS; k++) shadow_p0[k] <= '0;
      presc     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      if (bus.load) begin
        for (int k = 0; k < N_DIGITS; k++) shadow_p0[k] <= norm[k];
      end
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= round_end ? '0 : idx + 1'b1;
      if (!bus.blink_en) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (round_end) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    lead_blank  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      higher_zero   = higher_zero && (shadow_p0[k] == 4'd0);
      lead_blank[k] = higher_zero && (k != 0);
    end
  end

  always_comb begin
    an_hot      = '0;
    an_hot[idx] = 1'b1;
  end

  assign blank_cur = bus.blank_lead && lead_blank[idx];

  scan_display_driver_decode u_decode (
    .bcd (shadow_p0[idx]),
    .seg (seg_pat)
  );

  // ---- stage p1: registered pin drivers, polarity applied here only ----
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p1 <= SEG_BLANK ^ SEG_POL;
      an_p1  <= AN_POL;
    end else begin
      seg_p1 <= ((phase_on && !blank_cur) ? seg_pat : SEG_BLANK) ^ SEG_POL;
      an_p1  <= an_hot ^ AN_POL;
    end
  end

  assign bus.seg_out = seg_p1;
  assign bus.an_out  = an_p1;

endmodule

// File: tb/tb_scan_display_driver.sv
module tb_scan_display_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_display_driver_if #(.N_DIGITS(N)) bus ();

  scan_display_driver #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD), .NORM_MMSS(1), .ACTIVE_LOW(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared = 0;
  int mism     = 0;

  // Reference model: edges since reset, wraps since blink enabled, digit values.
  int         m_n;
  int         m_w;
  int         m_sh [N];
  logic [6:0] seg_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [6:0]     es;
    logic [N-1:0]   ea;
    logic           ld, be, bl, rs;
    logic [4*N-1:0] din;
    int             ix;
    bit             blank, on, wrap;
    int             d [N];
    ld = bus.load; be = bus.blink_en; bl = bus.blank_lead; din = bus.digits_in; rs = reset;
    if (rs) begin
      es = 7'd0;
      ea = '0;
    end else begin
      ix = (m_n / SD) % N;
      ea = '0;
      ea[ix] = 1'b1;
      blank = 0;
      if (bl && ix >= 1) begin
        blank = 1;
        for (int k = ix; k < N; k++) if (m_sh[k] != 0) blank = 0;
      end
      on = ((m_w / BD) % 2) == 0;
      es = (on && !blank) ? seg_tab[m_sh[ix]] : 7'd0;
    end
    @(posedge clk);
    #1;
    chk("seg_out", 32'(bus.seg_out), 32'(es));
    chk("an_out", 32'(bus.an_out), 32'(ea));
    if (rs) begin
      m_n = 0;
      m_w = 0;
      for (int k = 0; k < N; k++) m_sh[k] = 0;
    end else begin
      wrap = ((m_n % SD) == SD - 1) && (((m_n / SD) % N) == N - 1);
      if (!be) m_w = 0;
      else if (wrap) m_w++;
      if (ld) begin
        for (int k = 0; k < N; k++) d[k] = int'(din[4*k +: 4]);
        if (d[1] >= 6 && d[1] <= 9) begin
          d[1] = d[1] - 6;
          d[2] = (d[2] + 1) % 10;
        end
        for (int k = 0; k < N; k++) m_sh[k] = d[k];
      end
      m_n++;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic load_word(input logic [4*N-1:0] w);
    bus.digits_in = w;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'h40;
    m_n = 0; m_w = 0;
    for (int k = 0; k < N; k++) m_sh[k] = 0;

    reset = 1'b1;
    bus.load = 1'b0; bus.digits_in = '0; bus.blink_en = 1'b0; bus.blank_lead = 1'b0;
    run(3);
    reset = 1'b0;
    run(20);

    // mm:ss normalisation
    load_word({4'd0, 4'd1, 4'd7, 4'd5});
    run(16);
    load_word({4'd0, 4'd9, 4'd6, 4'd3});
    run(16);

    // leading-zero blanking
    bus.blank_lead = 1'b1;
    load_word(16'h0000);
    run(16);
    load_word({4'd0, 4'd0, 4'd5, 4'd0});
    run(16);
    bus.blank_lead = 1'b0;

    // invalid BCD shows a dash
    load_word({4'd0, 4'd0, 4'hA, 4'hC});
    run(16);

    // blinking from a round start
    load_word({4'd1, 4'd2, 4'd3, 4'd4});
    for (int j = 0; j < N * SD && !((m_n % (N * SD)) == 0); j++) tick();
    bus.blink_en = 1'b1;
    run(SD * N * BD * 2 + 8);
    bus.blink_en = 1'b0;
    run(8);

    // load coincident with a slot edge
    for (int j = 0; j < SD && (m_n % SD) != SD - 1; j++) tick();
    load_word({4'd2, 4'd8, 4'd4, 4'd1});
    run(12);

    // reset mid-slot
    run(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(12);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom;
      bus.load = (r % 8) == 0;
      bus.digits_in = 16'($urandom);
      if ((r % 37) == 5) bus.blink_en = ~bus.blink_en;
      if ((r % 23) == 7) bus.blank_lead = ~bus.blank_lead;
      reset = (r % 97) == 3;
      tick();
    end
    reset = 1'b0;
    bus.load = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
